// File: rtl/looper_pkg.sv
// Shared types for the looper memory sequencer.
// Pass FSM states, per-bank operations and mixer widths.
package looper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_GAP    = 2'd2,
    ST_MIX    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_SKIP = 2'd0,
    OP_ZERO = 2'd1,
    OP_REC  = 2'd2,
    OP_READ = 2'd3
  } op_t;

  localparam int SAT_DATA_W = 16;
  localparam int SAT_EXT_W  = 3;
  localparam int SAT_ACC_W  = SAT_DATA_W + SAT_EXT_W;

endpackage

// File: rtl/mix_sat_acc.sv
// Signed mixing accumulator with headroom bits.
// The output is the running sum clamped to the signed DATA_W range.
module mix_sat_acc
  import looper_pkg::*;
#(
  parameter int DATA_W = SAT_DATA_W,
  parameter int EXT_W  = SAT_EXT_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr,
  input  logic              add,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] sat
);

  localparam int ACC_W = DATA_W + EXT_W;

  logic [ACC_W-1:0] acc;
  logic [EXT_W:0]   top;
  logic             fits;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (add) begin
      acc <= acc + {{EXT_W{din[DATA_W-1]}}, din};
    end
  end

  // value fits when all bits above the DATA_W sign bit match it
  assign top  = acc[ACC_W-1:DATA_W-1];
  assign fits = (top == '0) || (top == '1);

  always_comb begin
    sat = acc[DATA_W-1:0];
    if (!fits) begin
      sat = acc[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                         : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/looper_mem_seq.sv
// Multi-bank looper: walks every bank once per sample tick,
// records/erases/plays through an async-strobed RAM and mixes.
module looper_mem_seq
  import looper_pkg::*;
#(
  parameter int NUM_BANKS = 8,
  parameter int DATA_W    = 16,
  parameter int BLK_W     = 23,
  parameter int ACC_CYC   = 4,
  parameter int MAX_BLOCK = 8000000
) (
  input  logic                               clk_100MHz,
  input  logic                               rstn,
  input  logic                               sample_tick,
  input  logic                               recording,
  input  logic                               playing,
  input  logic [$clog2(NUM_BANKS)-1:0]       rec_bank,
  input  logic                               delete_req,
  input  logic [$clog2(NUM_BANKS)-1:0]       delete_bank,
  input  logic [DATA_W-1:0]                  sample_in,
  output logic [DATA_W-1:0]                  mix_out,
  output logic                               mix_valid,
  output logic [BLK_W+$clog2(NUM_BANKS)-1:0] ram_a,
  output logic [DATA_W-1:0]                  ram_dq_i,
  input  logic [DATA_W-1:0]                  ram_dq_o,
  output logic                               ram_cen,
  output logic                               ram_oen,
  output logic                               ram_wen,
  output logic [NUM_BANKS-1:0]               active,
  output logic [BLK_W-1:0]                   cur_block,
  output logic                               busy,
  output logic                               overrun
);

  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int CYC_W  = (ACC_CYC > 1) ? $clog2(ACC_CYC) : 1;
  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);
  localparam logic [CYC_W-1:0]  LAST_CYC  = CYC_W'(ACC_CYC - 1);
  localparam logic [BLK_W-1:0]  MAX_LEN   = BLK_W'(MAX_BLOCK);

  state_t               state;
  op_t                  op_q;
  op_t                  nop;
  logic [BANK_W-1:0]    bank;
  logic [BANK_W-1:0]    nb;
  logic [CYC_W-1:0]     cyc;
  logic [NUM_BANKS-1:0] zeroing;
  logic [NUM_BANKS-1:0] set_mask;
  logic [NUM_BANKS-1:0] del_mask;
  logic [NUM_BANKS-1:0] active_n;
  logic [BLK_W-1:0]     loop_len;
  logic [DATA_W-1:0]    sat_q;

  logic rec_prev;
  logic first_rec;
  logic blk_rst_pend;
  logic enter;
  logic last_cyc;
  logic is_last;
  logic skip_done;
  logic acc_done;
  logic to_mix;
  logic wrap;
  logic del_empty;
  logic rec_rise;
  logic rec_fall;
  logic acc_clr;
  logic acc_add;

  assign busy      = (state != ST_IDLE);
  assign last_cyc  = (cyc == LAST_CYC);
  assign is_last   = (bank == LAST_BANK);
  assign skip_done = (state == ST_ACCESS) && (op_q == OP_SKIP);
  assign acc_done  = (state == ST_ACCESS) && (op_q != OP_SKIP)
                  && last_cyc;
  assign to_mix    = is_last && (skip_done || state == ST_GAP);

  assign acc_clr = (state == ST_IDLE) && sample_tick;
  assign acc_add = acc_done && (op_q == OP_READ);

  assign rec_rise = recording && !rec_prev;
  assign rec_fall = !recording && rec_prev;

  assign set_mask = (acc_done && op_q == OP_REC)
                  ? (NUM_BANKS'(1) << bank) : '0;
  assign del_mask = delete_req
                  ? (NUM_BANKS'(1) << delete_bank) : '0;
  // delete is applied last so it overrides a same-cycle set
  assign active_n  = (active | set_mask) & ~del_mask;
  assign del_empty = delete_req && (active_n == '0);

  assign wrap = (state == ST_MIX)
             && (blk_rst_pend || cur_block >= loop_len - 1'b1);

  always_comb begin
    enter = 1'b0;
    nb    = bank + 1'b1;
    unique case (state)
      ST_IDLE: begin
        enter = sample_tick;
        nb    = '0;
      end
      ST_ACCESS: enter = skip_done && !is_last;
      ST_GAP:    enter = !is_last;
      default:   enter = 1'b0;
    endcase
  end

  always_comb begin
    if (zeroing[nb])
      nop = OP_ZERO;
    else if (recording && nb == rec_bank)
      nop = OP_REC;
    else if (playing && active[nb])
      nop = OP_READ;
    else
      nop = OP_SKIP;
  end

  always_ff @(posedge clk_100MHz) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      op_q      <= OP_SKIP;
      bank      <= '0;
      cyc       <= '0;
      ram_a     <= '0;
      ram_dq_i  <= '0;
      ram_cen   <= 1'b1;
      ram_oen   <= 1'b1;
      ram_wen   <= 1'b1;
      mix_out   <= '0;
      mix_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      mix_valid <= 1'b0;
      if (sample_tick && busy)
        overrun <= 1'b1;
      unique case (state)
        ST_ACCESS: begin
          if (acc_done) begin
            state   <= ST_GAP;
            ram_cen <= 1'b1;
            ram_oen <= 1'b1;
            ram_wen <= 1'b1;
          end else if (!skip_done) begin
            cyc <= cyc + 1'b1;
          end
        end
        ST_MIX:  state <= ST_IDLE;
        default: ;
      endcase
      // strobes and address are fixed for the whole access
      if (enter) begin
        state    <= ST_ACCESS;
        bank     <= nb;
        op_q     <= nop;
        cyc      <= '0;
        ram_a    <= {cur_block, nb};
        ram_dq_i <= (nop == OP_REC) ? sample_in : '0;
        ram_cen  <= (nop == OP_SKIP);
        ram_wen  <= !(nop == OP_ZERO || nop == OP_REC);
        ram_oen  <= (nop != OP_READ);
      end
      if (to_mix) begin
        state     <= ST_MIX;
        mix_out   <= sat_q;
        mix_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (!rstn) begin
      active       <= '0;
      zeroing      <= '0;
      loop_len     <= MAX_LEN;
      cur_block    <= '0;
      rec_prev     <= 1'b0;
      first_rec    <= 1'b0;
      blk_rst_pend <= 1'b0;
    end else begin
      rec_prev <= recording;
      active   <= active_n;
      zeroing  <= (wrap ? '0 : zeroing) | del_mask;
      if (rec_rise)
        first_rec <= (active == '0);
      if (state == ST_MIX) begin
        cur_block    <= wrap ? '0 : cur_block + 1'b1;
        blk_rst_pend <= 1'b0;
      end
      if (del_empty) begin
        loop_len     <= MAX_LEN;
        blk_rst_pend <= 1'b1;
      end else if (rec_fall && first_rec) begin
        loop_len <= cur_block + 1'b1;
      end
    end
  end

  mix_sat_acc #(
    .DATA_W (DATA_W),
    .EXT_W  (BANK_W)
  ) u_acc (
    .clk  (clk_100MHz),
    .rstn (rstn),
    .clr  (acc_clr),
    .add  (acc_add),
    .din  (ram_dq_o),
    .sat  (sat_q)
  );

endmodule
